// File: rtl/alu_exec_pipe_if.sv
// Issue and writeback handshake bundle for the two-stage ALU execution pipe.
// master = issue station plus writeback consumer; slave = the pipe.
interface alu_exec_pipe_if #(
    parameter int INST_ID_BIT    = 8,
    parameter int REG_ID_BIT     = 3,
    parameter int IMM_BIT        = 4,
    parameter int DATA_BIT       = 16,
    parameter int SPEC_LEVEL_BIT = 3
);
    logic                      in_vld;
    logic                      in_rdy;
    logic [INST_ID_BIT-1:0]    in_id;
    logic [REG_ID_BIT-1:0]     in_dst_reg;
    logic [REG_ID_BIT-1:0]     in_src_reg0;
    logic [REG_ID_BIT-1:0]     in_src_reg1;
    logic [IMM_BIT-1:0]        in_imm;
    logic [SPEC_LEVEL_BIT-1:0] in_spec_level;

    logic                      out_vld;
    logic                      out_rdy;
    logic [INST_ID_BIT-1:0]    wb_id;
    logic [REG_ID_BIT-1:0]     wb_dst_reg;
    logic [DATA_BIT-1:0]       wb_data;
    logic [SPEC_LEVEL_BIT-1:0] wb_spec_level;

    modport master (
        output in_vld, in_id, in_dst_reg, in_src_reg0, in_src_reg1, in_imm, in_spec_level,
        input  in_rdy,
        input  out_vld, wb_id, wb_dst_reg, wb_data, wb_spec_level,
        output out_rdy
    );

    modport slave (
        input  in_vld, in_id, in_dst_reg, in_src_reg0, in_src_reg1, in_imm, in_spec_level,
        output in_rdy,
        output out_vld, wb_id, wb_dst_reg, wb_data, wb_spec_level,
        input  out_rdy
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage ALU pipe: S1 latches operands, S2 holds rf0 + rf1 + imm; latency 2, full throughput.
// Branch failure squashes entries at or above the failing level; success remaps stored levels.
module alu_exec_pipe #(
    parameter int INST_ID_BIT  = 8,
    parameter int NUM_REG      = 8,
    parameter int IMM_BIT      = 4,
    parameter int DATA_BIT     = 16,
    parameter int SPEC_DEPTH   = 4,
    localparam int REG_ID_BIT     = $clog2(NUM_REG),
    localparam int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    alu_exec_pipe_if.slave                            pipe,
    output logic [REG_ID_BIT-1:0]                     rf_rd_addr0,
    output logic [REG_ID_BIT-1:0]                     rf_rd_addr1,
    input  logic [DATA_BIT-1:0]                       rf_rd_data0,
    input  logic [DATA_BIT-1:0]                       rf_rd_data1,
    output logic [NUM_REG-1:0]                        pending_write,
    output logic                                      empty,
    input  logic                                      br_pred_vld,
    input  logic                                      br_pred_succ,
    input  logic [SPEC_LEVEL_BIT-1:0]                 br_pred_fail_level,
    input  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0]  br_pred_succ_nxt_levels,
    output logic                                      br_pred_rdy
);
    localparam int SLB = SPEC_LEVEL_BIT;

    logic                   s1_vld, s2_vld;
    logic [INST_ID_BIT-1:0] s1_id, s2_id;
    logic [REG_ID_BIT-1:0]  s1_dst, s2_dst;
    logic [SLB-1:0]         s1_lvl, s2_lvl;
    logic [DATA_BIT-1:0]    s1_d0, s1_d1, s2_data;
    logic [IMM_BIT-1:0]     s1_imm;

    logic br_fail, br_succ, s1_rb, s2_rb, in_drop, s2_adv, accept;
    logic [SLB-1:0] s1_lvl_remap, s2_lvl_remap;

    // Levels outside the table are left untouched.
    function automatic logic [SLB-1:0] remap(input logic [SLB-1:0] lvl,
                                             input logic [SLB*(SPEC_DEPTH+1)-1:0] tbl);
        remap = lvl;
        for (int i = 0; i <= SPEC_DEPTH; i++)
            if (lvl == SLB'(i))
                remap = tbl[i*SLB +: SLB];
    endfunction

    assign br_fail      = br_pred_vld && !br_pred_succ;
    assign br_succ      = br_pred_vld && br_pred_succ;
    assign s1_rb        = s1_vld && br_fail && (s1_lvl >= br_pred_fail_level);
    assign s2_rb        = s2_vld && br_fail && (s2_lvl >= br_pred_fail_level);
    assign in_drop      = br_fail && (pipe.in_spec_level >= br_pred_fail_level);
    assign s1_lvl_remap = remap(s1_lvl, br_pred_succ_nxt_levels);
    assign s2_lvl_remap = remap(s2_lvl, br_pred_succ_nxt_levels);

    assign s2_adv      = !s2_vld || pipe.out_rdy;
    assign pipe.in_rdy = !s1_vld || s2_adv;
    assign accept      = pipe.in_vld && pipe.in_rdy;
    assign br_pred_rdy = 1'b1;

    assign rf_rd_addr0 = pipe.in_src_reg0;
    assign rf_rd_addr1 = pipe.in_src_reg1;

    assign pipe.out_vld       = s2_vld && !s2_rb;
    assign pipe.wb_id         = s2_id;
    assign pipe.wb_dst_reg    = s2_dst;
    assign pipe.wb_data       = s2_data;
    assign pipe.wb_spec_level = br_succ ? s2_lvl_remap : s2_lvl;

    assign empty = !s1_vld && !s2_vld;

    always_comb begin
        pending_write = '0;
        for (int i = 0; i < NUM_REG; i++)
            pending_write[i] = (s1_vld && s1_dst == REG_ID_BIT'(i)) ||
                               (s2_vld && s2_dst == REG_ID_BIT'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (pipe.in_rdy)
                s1_vld <= accept && !in_drop;
            else
                s1_vld <= s1_vld && !s1_rb;
            if (s2_adv)
                s2_vld <= s1_vld && !s1_rb;
            else
                s2_vld <= s2_vld && !s2_rb;
        end
    end

    // Payload and levels carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_id  <= pipe.in_id;
            s1_dst <= pipe.in_dst_reg;
            s1_lvl <= pipe.in_spec_level;
            s1_d0  <= rf_rd_data0;
            s1_d1  <= rf_rd_data1;
            s1_imm <= pipe.in_imm;
        end else if (br_succ) begin
            s1_lvl <= s1_lvl_remap;
        end

        if (s2_adv) begin
            s2_id   <= s1_id;
            s2_dst  <= s1_dst;
            s2_lvl  <= br_succ ? s1_lvl_remap : s1_lvl;
            s2_data <= s1_d0 + s1_d1 + DATA_BIT'(s1_imm);
        end else if (br_succ) begin
            s2_lvl <= s2_lvl_remap;
        end
    end
endmodule
